// File: rtl/jk_ff_monitor_if.sv
// Observation bus for the JK flip-flop checker: tapped stimulus/q in, run results out.
// JK_MON_FIRST_ERR_EN adds first_err_idx to the bus.
interface jk_ff_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             j;
    logic             k;
    logic             q;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] toggle_count;
    logic [CNT_W-1:0] err_count;
`ifdef JK_MON_FIRST_ERR_EN
    logic [15:0]      first_err_idx;
`endif

    modport master (
        output j, k, q, start,
        input  busy, done, err, toggle_count, err_count
`ifdef JK_MON_FIRST_ERR_EN
      , input  first_err_idx
`endif
    );

    modport slave (
        input  j, k, q, start,
        output busy, done, err, toggle_count, err_count
`ifdef JK_MON_FIRST_ERR_EN
      , output first_err_idx
`endif
    );
endinterface

// File: rtl/jk_ff_monitor.sv
// Cycle-accurate JK reference checker: counts q toggles and model mismatches over WINDOW samples.
// JK_MON_FIRST_ERR_EN adds first_err_idx (index of first mismatch, 16'hFFFF if none).
module jk_ff_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clock,
    input  logic             reset,
    jk_ff_monitor_if.slave   bus
);
    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_SYNC  = 2'd1;
    localparam logic [1:0]       S_RUN   = 2'd2;
    localparam logic [1:0]       S_DONE  = 2'd3;
    localparam logic [15:0]      LAST    = 16'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [15:0]      idx_q, idx_d;
    logic [CNT_W-1:0] tog_q, tog_d, ec_q, ec_d;
    logic             err_q, err_d;
    logic             j_hist_q, k_hist_q, q_hist_q;
    logic             exp_q, mismatch, toggled, clear;

    always_comb begin
        unique case ({j_hist_q, k_hist_q})
            2'b10:   exp_q = 1'b1;
            2'b01:   exp_q = 1'b0;
            2'b11:   exp_q = ~q_hist_q;
            default: exp_q = q_hist_q;
        endcase
    end

    assign mismatch = (bus.q != exp_q);
    assign toggled  = (bus.q != q_hist_q);
    assign clear    = bus.start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tog_d   = tog_q;
        ec_d    = ec_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (clear) state_d = S_SYNC;
            S_SYNC: state_d = S_RUN;
            S_RUN: begin
                if (mismatch) begin
                    err_d = 1'b1;
                    if (ec_q != CNT_MAX) ec_d = ec_q + 1'b1;
                end
                if (toggled && tog_q != CNT_MAX) tog_d = tog_q + 1'b1;
                idx_d = idx_q + 16'd1;
                if (idx_q == LAST) state_d = S_DONE;
            end
            default: state_d = clear ? S_SYNC : S_IDLE;
        endcase
        // Accepted start wipes the previous results on the same edge
        if (clear) begin
            idx_d = '0;
            tog_d = '0;
            ec_d  = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tog_q    <= '0;
            ec_q     <= '0;
            err_q    <= 1'b0;
            j_hist_q <= 1'b0;
            k_hist_q <= 1'b0;
            q_hist_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tog_q    <= tog_d;
            ec_q     <= ec_d;
            err_q    <= err_d;
            j_hist_q <= bus.j;
            k_hist_q <= bus.k;
            q_hist_q <= bus.q;
        end
    end

`ifdef JK_MON_FIRST_ERR_EN
    logic [15:0] fe_q, fe_d;

    always_comb begin
        fe_d = fe_q;
        if (clear) begin
            fe_d = '0;
        end else if (state_q == S_RUN) begin
            if (mismatch && !err_q)
                fe_d = idx_q;
            // Valid already in the DONE cycle, so resolve "no mismatch" on the last sample
            else if (idx_q == LAST && !err_q && !mismatch)
                fe_d = 16'hFFFF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) fe_q <= '0;
        else       fe_q <= fe_d;
    end

    assign bus.first_err_idx = fe_q;
`endif

    assign bus.busy         = (state_q == S_SYNC) || (state_q == S_RUN);
    assign bus.done         = (state_q == S_DONE) && !reset;
    assign bus.err          = err_q;
    assign bus.toggle_count = tog_q;
    assign bus.err_count    = ec_q;
endmodule
